// File: rtl/dataflow_deadlock_scanner.sv
// Deadlock scanner for an HLS dataflow region: qualifies an all-blocked condition,
// snapshots the blocked processes and reports their indices. Optional DEADLOCK_TS_EN adds report_ts.
module dataflow_deadlock_scanner #(
    parameter int unsigned NPROC  = 4,
    parameter int unsigned IDX_W  = 2,
    parameter int unsigned THRESH = 16,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [NPROC-1:0] proc_idle,
    input  logic [NPROC-1:0] proc_block,
    input  logic             clear,
    output logic             deadlock,
    output logic             report_valid,
    input  logic             report_ready,
    output logic [IDX_W-1:0] report_idx,
    output logic             report_last
`ifdef DEADLOCK_TS_EN
    ,
    output logic [CNT_W-1:0] report_ts
`endif
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_MONITOR = 3'd1;
    localparam logic [2:0] S_CAPTURE = 3'd2;
    localparam logic [2:0] S_SCAN    = 3'd3;
    localparam logic [2:0] S_REPORT  = 3'd4;
    localparam logic [2:0] S_HOLD    = 3'd5;

    logic [2:0]       state, state_next;
    logic [CNT_W-1:0] counter, counter_next;
    logic [NPROC-1:0] snapshot, snapshot_next;
    logic [IDX_W-1:0] ptr, ptr_next;
    logic             deadlock_next;
    logic             report_valid_next;
    logic [IDX_W-1:0] report_idx_next;
    logic             report_last_next;
    logic             all_blocked;
    logic             upper_set;

    // At least one active process, and every active process is blocked.
    assign all_blocked = (|(~proc_idle)) & (&(proc_block | proc_idle));

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= S_IDLE;
            counter      <= '0;
            snapshot     <= '0;
            ptr          <= '0;
            deadlock     <= 1'b0;
            report_valid <= 1'b0;
            report_idx   <= '0;
            report_last  <= 1'b0;
        end else begin
            state        <= state_next;
            counter      <= counter_next;
            snapshot     <= snapshot_next;
            ptr          <= ptr_next;
            deadlock     <= deadlock_next;
            report_valid <= report_valid_next;
            report_idx   <= report_idx_next;
            report_last  <= report_last_next;
        end
    end

    always_comb begin
        state_next        = state;
        counter_next      = counter;
        snapshot_next     = snapshot;
        ptr_next          = ptr;
        deadlock_next     = deadlock;
        report_valid_next = report_valid;
        report_idx_next   = report_idx;
        report_last_next  = report_last;

        // Any snapshot bit strictly above the scan pointer means more reports follow.
        upper_set = 1'b0;
        for (int i = 0; i < int'(NPROC); i++) begin
            if (i > int'(ptr)) begin
                upper_set = upper_set | snapshot[i];
            end
        end

        case (state)
            S_IDLE: begin
                if (enable) begin
                    state_next   = S_MONITOR;
                    counter_next = '0;
                end
            end
            S_MONITOR: begin
                if (!enable) begin
                    state_next   = S_IDLE;
                    counter_next = '0;
                end else if (!all_blocked) begin
                    counter_next = '0;
                end else if (counter == CNT_W'(THRESH - 1)) begin
                    state_next    = S_CAPTURE;
                    snapshot_next = proc_block & ~proc_idle;
                    deadlock_next = 1'b1;
                end else begin
                    counter_next = counter + CNT_W'(1);
                end
            end
            S_CAPTURE: begin
                ptr_next   = '0;
                state_next = S_SCAN;
            end
            S_SCAN: begin
                if (snapshot[ptr]) begin
                    state_next        = S_REPORT;
                    report_valid_next = 1'b1;
                    report_idx_next   = ptr;
                    report_last_next  = ~upper_set;
                end else if (ptr == IDX_W'(NPROC - 1)) begin
                    state_next = S_HOLD;
                end else begin
                    ptr_next = ptr + IDX_W'(1);
                end
            end
            S_REPORT: begin
                if (report_ready) begin
                    report_valid_next = 1'b0;
                    if (report_last) begin
                        state_next = S_HOLD;
                    end else begin
                        ptr_next   = ptr + IDX_W'(1);
                        state_next = S_SCAN;
                    end
                end
            end
            S_HOLD: begin
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        // Clear overrides any handshake or threshold hit in the same cycle.
        if (clear && (state != S_IDLE)) begin
            state_next        = enable ? S_MONITOR : S_IDLE;
            counter_next      = '0;
            snapshot_next     = snapshot;
            deadlock_next     = 1'b0;
            report_valid_next = 1'b0;
            report_last_next  = 1'b0;
            report_idx_next   = '0;
        end
    end

`ifdef DEADLOCK_TS_EN
    logic [CNT_W-1:0] ts_cnt;

    // Free-running cycle count, sampled on the MONITOR -> CAPTURE transition.
    always_ff @(posedge clock) begin
        if (reset) begin
            ts_cnt    <= '0;
            report_ts <= '0;
        end else begin
            ts_cnt <= ts_cnt + CNT_W'(1);
            if ((state == S_MONITOR) && (state_next == S_CAPTURE)) begin
                report_ts <= ts_cnt;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dataflow_deadlock_scanner.sv
// Directed bench for dataflow_deadlock_scanner; report_ts checks compile in with DEADLOCK_TS_EN.
module tb_dataflow_deadlock_scanner;

    logic       clock;
    logic       reset;
    logic       enable;
    logic [3:0] proc_idle;
    logic [3:0] proc_block;
    logic       clear;
    logic       deadlock;
    logic       report_valid;
    logic       report_ready;
    logic [1:0] report_idx;
    logic       report_last;
`ifdef DEADLOCK_TS_EN
    logic [15:0] report_ts;
`endif

    int tests;
    int fails;

    dataflow_deadlock_scanner #(
        .NPROC(4), .IDX_W(2), .THRESH(16), .CNT_W(16)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .proc_idle   (proc_idle),
        .proc_block  (proc_block),
        .clear       (clear),
        .deadlock    (deadlock),
        .report_valid(report_valid),
        .report_ready(report_ready),
        .report_idx  (report_idx),
        .report_last (report_last)
`ifdef DEADLOCK_TS_EN
        ,
        .report_ts   (report_ts)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Advance until report_valid is seen or the budget runs out.
    task automatic wait_valid(output bit seen);
        int n;
        n = 0;
        while (!report_valid && n < 10) begin
            step(1);
            n++;
        end
        seen = report_valid;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step(1);
        clear = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; clear = 1'b0; report_ready = 1'b0;
        proc_idle = 4'b0000; proc_block = 4'b0000;
        step(2);
        reset = 1'b0;
        step(1);
        tests++; if (deadlock !== 1'b0) begin fails++; $display("FAIL reset_deadlock got %b exp 0", deadlock); end
        tests++; if (report_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", report_valid); end
        tests++; if (report_idx !== 2'd0) begin fails++; $display("FAIL reset_idx got %0d exp 0", report_idx); end
        tests++; if (report_last !== 1'b0) begin fails++; $display("FAIL reset_last got %b exp 0", report_last); end
    endtask

    task automatic test_full_block();
        bit seen;
        enable = 1'b1;
        step(1);
        proc_idle = 4'b0000; proc_block = 4'b1111;
        step(15);
        tests++; if (deadlock !== 1'b0) begin fails++; $display("FAIL full_early got %b exp 0", deadlock); end
        step(1);
        tests++; if (deadlock !== 1'b1) begin fails++; $display("FAIL full_deadlock got %b exp 1", deadlock); end
        report_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_valid(seen);
            tests++; if (seen !== 1'b1) begin fails++; $display("FAIL full_valid%0d got %b exp 1", i, seen); end
            tests++; if (report_idx !== 2'(i)) begin fails++; $display("FAIL full_idx%0d got %0d exp %0d", i, report_idx, i); end
            tests++; if (report_last !== (i == 3)) begin fails++; $display("FAIL full_last%0d got %b exp %b", i, report_last, (i == 3)); end
            step(1);
        end
        step(3);
        tests++; if (report_valid !== 1'b0) begin fails++; $display("FAIL hold_valid got %b exp 0", report_valid); end
        tests++; if (deadlock !== 1'b1) begin fails++; $display("FAIL hold_deadlock got %b exp 1", deadlock); end
        proc_block = 4'b0000;
        pulse_clear();
        tests++; if (deadlock !== 1'b0) begin fails++; $display("FAIL full_clear got %b exp 0", deadlock); end
    endtask

    task automatic test_restart();
        report_ready = 1'b0;
        proc_block = 4'b1111;
        step(15);
        proc_block = 4'b1110;
        step(1);
        tests++; if (deadlock !== 1'b0) begin fails++; $display("FAIL restart_drop got %b exp 0", deadlock); end
        proc_block = 4'b1111;
        step(15);
        tests++; if (deadlock !== 1'b0) begin fails++; $display("FAIL restart_early got %b exp 0", deadlock); end
        step(1);
        tests++; if (deadlock !== 1'b1) begin fails++; $display("FAIL restart_hit got %b exp 1", deadlock); end
        proc_block = 4'b0000;
        pulse_clear();
        tests++; if (deadlock !== 1'b0) begin fails++; $display("FAIL restart_clear got %b exp 0", deadlock); end
    endtask

    task automatic test_partial();
        bit seen;
        proc_idle = 4'b0101; proc_block = 4'b1010;
        step(16);
        tests++; if (deadlock !== 1'b1) begin fails++; $display("FAIL part_deadlock got %b exp 1", deadlock); end
        proc_idle = 4'b0000; proc_block = 4'b0001;
        report_ready = 1'b1;
        wait_valid(seen);
        tests++; if (seen !== 1'b1) begin fails++; $display("FAIL part_valid0 got %b exp 1", seen); end
        tests++; if (report_idx !== 2'd1) begin fails++; $display("FAIL part_idx0 got %0d exp 1", report_idx); end
        tests++; if (report_last !== 1'b0) begin fails++; $display("FAIL part_last0 got %b exp 0", report_last); end
        step(1);
        wait_valid(seen);
        tests++; if (seen !== 1'b1) begin fails++; $display("FAIL part_valid1 got %b exp 1", seen); end
        tests++; if (report_idx !== 2'd3) begin fails++; $display("FAIL part_idx1 got %0d exp 3", report_idx); end
        tests++; if (report_last !== 1'b1) begin fails++; $display("FAIL part_last1 got %b exp 1", report_last); end
        step(1);
        tests++; if (report_valid !== 1'b0) begin fails++; $display("FAIL part_done got %b exp 0", report_valid); end
        proc_block = 4'b0000;
        pulse_clear();
        proc_idle = 4'b1111; proc_block = 4'b1111;
        step(20);
        tests++; if (deadlock !== 1'b0) begin fails++; $display("FAIL all_idle got %b exp 0", deadlock); end
        proc_idle = 4'b0000; proc_block = 4'b0000;
        step(1);
    endtask

    task automatic test_backpressure();
        bit seen;
        report_ready = 1'b0;
        proc_block = 4'b1111;
        step(16);
        tests++; if (deadlock !== 1'b1) begin fails++; $display("FAIL bp_deadlock got %b exp 1", deadlock); end
        wait_valid(seen);
        tests++; if (seen !== 1'b1) begin fails++; $display("FAIL bp_valid got %b exp 1", seen); end
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            tests++;
            if ({report_valid, report_idx, report_last} !== 4'b1_00_0) begin
                fails++;
                $display("FAIL bp_stable%0d got v=%b i=%0d l=%b exp v=1 i=0 l=0", i, report_valid, report_idx, report_last);
            end
        end
        proc_block = 4'b0000;
        report_ready = 1'b1;
        enable = 1'b1;
        pulse_clear();
        tests++; if (report_valid !== 1'b0) begin fails++; $display("FAIL bp_clear_valid got %b exp 0", report_valid); end
        tests++; if (deadlock !== 1'b0) begin fails++; $display("FAIL bp_clear_deadlock got %b exp 0", deadlock); end
        step(3);
        tests++; if (report_valid !== 1'b0) begin fails++; $display("FAIL bp_no_resume got %b exp 0", report_valid); end
    endtask

    task automatic test_reset_mid_scan();
        report_ready = 1'b1;
        proc_idle = 4'b0111; proc_block = 4'b1000;
        step(16);
        tests++; if (deadlock !== 1'b1) begin fails++; $display("FAIL mid_deadlock got %b exp 1", deadlock); end
        step(2);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        tests++;
        if ({deadlock, report_valid, report_idx, report_last} !== 5'b0) begin
            fails++;
            $display("FAIL mid_reset got d=%b v=%b i=%0d l=%b exp all 0", deadlock, report_valid, report_idx, report_last);
        end
        enable = 1'b0;
        proc_idle = 4'b0000; proc_block = 4'b1111;
        step(20);
        tests++; if (deadlock !== 1'b0) begin fails++; $display("FAIL disabled got %b exp 0", deadlock); end
        tests++; if (report_valid !== 1'b0) begin fails++; $display("FAIL disabled_valid got %b exp 0", report_valid); end
        proc_block = 4'b0000;
    endtask

`ifdef DEADLOCK_TS_EN
    task automatic test_timestamp();
        reset = 1'b1; enable = 1'b0; clear = 1'b0; report_ready = 1'b0;
        proc_idle = 4'b0000; proc_block = 4'b0000;
        step(1);
        reset = 1'b0;
        tests++; if (report_ts !== 16'd0) begin fails++; $display("FAIL ts_reset got %0d exp 0", report_ts); end
        enable = 1'b1;
        proc_block = 4'b1111;
        step(1);
        step(16);
        tests++; if (deadlock !== 1'b1) begin fails++; $display("FAIL ts_deadlock got %b exp 1", deadlock); end
        tests++; if (report_ts !== 16'd16) begin fails++; $display("FAIL ts_value got %0d exp 16", report_ts); end
        step(5);
        tests++; if (report_ts !== 16'd16) begin fails++; $display("FAIL ts_hold got %0d exp 16", report_ts); end
    endtask
`endif

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_full_block();
        test_restart();
        test_partial();
        test_backpressure();
        test_reset_mid_scan();
`ifdef DEADLOCK_TS_EN
        test_timestamp();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
